sd_tile_loader: RTL and testbench
=================================

# sd_tile_loader

Loads tile graphics from the SD card into the tile memory feeding the TFT screen writer. Sits directly downstream of `SD_SPI`:
- consumes its byte stream (`InputData`, `InputDataClock`, `EnableDataRead`);
- drives its sector address (`InputAddress`);
- packs byte pairs into RGB565 pixels and writes them into tile memory.

One 512-byte sector holds exactly one 16×16 tile, so tiles are fetched one sector at a time.

## Interface
Parameters:
- `START_SECTOR`, 16'h0002, SD sector of tile 0.
- `TILE_BITS`, 5, log2 of the tile count (default 32 tiles); write address width is `TILE_BITS+8`.

Ports:
- `MasterCLK`  in  1  system clock. Single clock domain; every flop is on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  one-cycle pulse that begins a full load.
- `SD_InputData`  in  8  byte from `SD_SPI`; stable for ≥4 `MasterCLK` cycles after each `SD_InputDataClock` rising edge.
- `SD_InputDataClock`  in  1  byte strobe from `SD_SPI`; asynchronous to `MasterCLK`, synchronized internally.
- `SD_EnableDataRead`  in  1  high while `SD_SPI` is streaming a sector; synchronized internally.
- `SD_InputAddress`  out  16  sector address presented to `SD_SPI`.
- `Tile_WrEn`  out  1  one-cycle pixel write strobe.
- `Tile_WrAddr`  out  `TILE_BITS+8`  write address {tile, y[3:0], x[3:0]}.
- `Tile_WrData`  out  16  RGB565 pixel.
- `Busy`  out  1  high while a load is in progress.
- `Done`  out  1  high after a successful load; cleared by the next `Start`.
- `Error`  out  1  high after an aborted sector; cleared by the next `Start`.

## Operation
- **Input synchronization:** `SD_InputDataClock` and `SD_EnableDataRead` each pass through 2 flops. A third flop on the data-clock path provides rising-edge detection. Each detected rising edge while in RECV captures `SD_InputData` as one byte.
- **IDLE:** waiting for a load.
  - `Start` → REQ.
  - On entry from `Start`: tile counter = 0, `SD_InputAddress` = `START_SECTOR`, `Done` = `Error` = 0, `Busy` = 1.
- **REQ:** waiting for the sector stream to begin.
  - Synchronized `EnableDataRead` high → RECV.
  - Byte counter (9 bits) = 0 on entry to RECV.
- **RECV:** receiving the sector.
  - Even byte (counter bit 0 = 0) is latched as the high byte.
  - Odd byte completes the pixel; `Tile_WrEn` pulses with data {high, low} and address {tile, byte_cnt[8:1]}.
  - After byte 511 → NEXT.
  - Synchronized `EnableDataRead` low before 512 bytes → ABORT.
- **NEXT:** advance to the next sector.
  - If tile == 2^`TILE_BITS` − 1 → DONE.
  - Otherwise tile += 1, `SD_InputAddress` += 1, then wait for synchronized `EnableDataRead` low → REQ.
- **DONE:** `Done` = 1, `Busy` = 0 → IDLE.
- **ABORT:** `Error` = 1, `Busy` = 0, no further writes → IDLE. `SD_InputAddress` holds the failing sector.
- **Start handling:** `Start` while `Busy` is ignored.
- **Stray edges:** data-clock edges outside RECV are discarded.
- **Address arithmetic:** `SD_InputAddress` wraps modulo 2^16. The tile counter never wraps; the NEXT check stops it at the last tile.

## Timing
- **Reset values:**
  - `SD_InputAddress` = `START_SECTOR`.
  - `Tile_WrEn`, `Tile_WrAddr`, `Tile_WrData`, `Busy`, `Done`, `Error` = 0.
  - State = IDLE; all counters and synchronizers = 0.
- **Reset mid-load:** takes effect immediately. Any in-flight pixel is dropped and no write strobe follows.
- **Byte capture latency:** 3 `MasterCLK` cycles from a `SD_InputDataClock` rising edge at the pin to byte capture.
- **Write strobe:** `Tile_WrEn` is registered and asserted the cycle after an odd byte is captured. Address and data are valid in that same cycle.
- **Byte spacing:** minimum 4 `MasterCLK` cycles between data-clock edges.
- **`Busy`:** rises the cycle after `Start`; falls on the cycle DONE or ABORT is entered.
- **Write ordering:** the last pixel write of the last tile precedes `Done` by 2 cycles.

## Configuration
- Macro: `SD_TILE_LOADER_LITTLE_ENDIAN_EN`.
- Defined: the even byte is the low half of the pixel; `Tile_WrData` = {odd, even}.
- Undefined (default): big-endian; `Tile_WrData` = {even, odd}.
- All other behaviour is identical either way.

## Test plan
- Reset low mid-RECV after 100 bytes → all outputs return to reset values at once; a later `Start` reloads from sector 0x0002.
- `Start`, model serves 32 sectors; byte n of tile t = (t+n)&0xFF → 8192 writes; tile 3 pixel 0 is 0x0304 at address 0x300; `Done` = 1, `Error` = 0.
- Same stimulus with `SD_TILE_LOADER_LITTLE_ENDIAN_EN` defined → tile 3 pixel 0 is 0x0403.
- `EnableDataRead` dropped after 301 bytes of sector 0x0005 → 150 writes for that tile, `Error` = 1, `Busy` = 0, `SD_InputAddress` = 0x0005.
- `Start` pulsed repeatedly during a load, plus data-clock edges while in REQ → no restart, no extra writes, write count still 8192.
- `TILE_BITS` = 1, `START_SECTOR` = 16'hFFFF → sectors 0xFFFF then 0x0000 requested; `Done` after 512 writes.

Source files
------------

// File: rtl/sd_tile_loader.sv
// Streams 512-byte SD sectors into tile memory as RGB565 pixels, one sector per 16x16 tile.
// Optional macro SD_TILE_LOADER_LITTLE_ENDIAN_EN: even byte becomes the low half of each pixel.
module sd_tile_loader #(
    parameter logic [15:0] START_SECTOR = 16'h0002,
    parameter int          TILE_BITS    = 5
) (
    input  logic                   MasterCLK,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [7:0]             SD_InputData,
    input  logic                   SD_InputDataClock,
    input  logic                   SD_EnableDataRead,
    output logic [15:0]            SD_InputAddress,
    output logic                   Tile_WrEn,
    output logic [TILE_BITS+7:0]   Tile_WrAddr,
    output logic [15:0]            Tile_WrData,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Error
);

    // state   | meaning
    // IDLE    | waiting for Start
    // REQ     | sector requested, waiting for the stream to begin
    // RECV    | capturing sector bytes, writing a pixel per byte pair
    // NEXT    | sector complete; finish or step to the next tile
    // WAIT    | waiting for the previous stream to end before re-arming
    // DONE    | raise Done, return to IDLE
    // ABORT   | raise Error, return to IDLE
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_RECV  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ABORT = 3'd6;

    localparam logic [TILE_BITS-1:0] LAST_TILE = '1;
    localparam logic [TILE_BITS-1:0] TILE_ONE  = TILE_BITS'(1);

    logic                 dclk_s1, dclk_s2, dclk_s3;
    logic                 en_s1, en_s2;
    logic                 byte_strobe;
    logic [2:0]           state;
    logic [TILE_BITS-1:0] tile;
    logic [8:0]           byte_cnt;
    logic [7:0]           even_byte;
    logic [15:0]          pixel;

    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            dclk_s1 <= 1'b0;
            dclk_s2 <= 1'b0;
            dclk_s3 <= 1'b0;
            en_s1   <= 1'b0;
            en_s2   <= 1'b0;
        end else begin
            dclk_s1 <= SD_InputDataClock;
            dclk_s2 <= dclk_s1;
            dclk_s3 <= dclk_s2;
            en_s1   <= SD_EnableDataRead;
            en_s2   <= en_s1;
        end
    end

    assign byte_strobe = dclk_s2 & ~dclk_s3;

`ifdef SD_TILE_LOADER_LITTLE_ENDIAN_EN
    assign pixel = {SD_InputData, even_byte};
`else
    assign pixel = {even_byte, SD_InputData};
`endif

    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            state           <= S_IDLE;
            tile            <= '0;
            byte_cnt        <= '0;
            even_byte       <= '0;
            SD_InputAddress <= START_SECTOR;
            Tile_WrEn       <= 1'b0;
            Tile_WrAddr     <= '0;
            Tile_WrData     <= '0;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            Error           <= 1'b0;
        end else begin
            Tile_WrEn <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state           <= S_REQ;
                        tile            <= '0;
                        SD_InputAddress <= START_SECTOR;
                        Done            <= 1'b0;
                        Error           <= 1'b0;
                        Busy            <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (en_s2) begin
                        state    <= S_RECV;
                        byte_cnt <= '0;
                    end
                end
                S_RECV: begin
                    // A byte arriving together with the enable drop still counts.
                    if (byte_strobe) begin
                        byte_cnt <= byte_cnt + 9'd1;
                        if (!byte_cnt[0]) begin
                            even_byte <= SD_InputData;
                        end else begin
                            Tile_WrEn   <= 1'b1;
                            Tile_WrAddr <= {tile, byte_cnt[8:1]};
                            Tile_WrData <= pixel;
                        end
                        if (byte_cnt == 9'd511) begin
                            state <= S_NEXT;
                        end
                    end else if (!en_s2) begin
                        state <= S_ABORT;
                        Busy  <= 1'b0;
                    end
                end
                S_NEXT: begin
                    if (tile == LAST_TILE) begin
                        state <= S_DONE;
                        Busy  <= 1'b0;
                    end else begin
                        tile            <= tile + TILE_ONE;
                        SD_InputAddress <= SD_InputAddress + 16'd1;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!en_s2) begin
                        state <= S_REQ;
                    end
                end
                S_DONE: begin
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_ABORT: begin
                    Error <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_tile_loader.sv
// Directed/randomized bench: an SD stream model feeds two loader instances, a queue scoreboard checks every write.
module tb_sd_tile_loader;

    logic        clk;
    logic        rst_n;
    logic        a_start, b_start;
    logic [7:0]  sd_data;
    logic        sd_dclk, sd_en;

    logic [15:0] a_addr, b_addr;
    logic        a_wr_en, b_wr_en;
    logic [12:0] a_wr_addr;
    logic [8:0]  b_wr_addr;
    logic [15:0] a_wr_data, b_wr_data;
    logic        a_busy, a_done, a_err;
    logic        b_busy, b_done, b_err;

    int checks;
    int failures;
    int cyc;
    int a_wr_cnt, b_wr_cnt;
    int a_last_wr, a_done_cyc;
    logic a_done_d;
    logic [15:0] a_px300;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    sd_tile_loader u_a (
        .MasterCLK(clk), .Reset(rst_n), .Start(a_start),
        .SD_InputData(sd_data), .SD_InputDataClock(sd_dclk), .SD_EnableDataRead(sd_en),
        .SD_InputAddress(a_addr), .Tile_WrEn(a_wr_en), .Tile_WrAddr(a_wr_addr),
        .Tile_WrData(a_wr_data), .Busy(a_busy), .Done(a_done), .Error(a_err)
    );

    sd_tile_loader #(.START_SECTOR(16'hFFFF), .TILE_BITS(1)) u_b (
        .MasterCLK(clk), .Reset(rst_n), .Start(b_start),
        .SD_InputData(sd_data), .SD_InputDataClock(sd_dclk), .SD_EnableDataRead(sd_en),
        .SD_InputAddress(b_addr), .Tile_WrEn(b_wr_en), .Tile_WrAddr(b_wr_addr),
        .Tile_WrData(b_wr_data), .Busy(b_busy), .Done(b_done), .Error(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && a_wr_en) begin
            a_wr_cnt  = a_wr_cnt + 1;
            a_last_wr = cyc;
            if (a_wr_addr == 13'h300) a_px300 = a_wr_data;
            if (q_a.size() == 0) chk("a_extra_write", 32'(q_a.size()), 32'd1);
            else chk("a_write", {3'b0, a_wr_addr, a_wr_data}, q_a.pop_front());
        end
        if (rst_n && a_done && !a_done_d) a_done_cyc = cyc;
        a_done_d = a_done;
    end

    always @(negedge clk) begin
        if (rst_n && b_wr_en) begin
            b_wr_cnt = b_wr_cnt + 1;
            if (q_b.size() == 0) chk("b_extra_write", 32'(q_b.size()), 32'd1);
            else chk("b_write", {7'b0, b_wr_addr, b_wr_data}, q_b.pop_front());
        end
    end

    // Byte n of tile t is (t+n)&0xFF; each odd byte completes pixel n/2 of that tile.
    task automatic send_bytes(input bit to_b, input int t, input int nbytes, input bit fast, input bit spam);
        int spam_n;
        logic [7:0] prev, cur;
        logic [15:0] px;
        logic [31:0] exp;
        spam_n = spam ? int'($urandom_range(0, 511)) : -1;
        prev = 8'h00;
        for (int n = 0; n < nbytes; n++) begin
            cur = 8'((t + n) & 255);
            sd_data = cur;
            sd_dclk = 1'b1;
            if (n % 2 == 1) begin
`ifdef SD_TILE_LOADER_LITTLE_ENDIAN_EN
                px = {cur, prev};
`else
                px = {prev, cur};
`endif
                exp = (32'(t * 256 + n / 2) << 16) | 32'(px);
                if (to_b) q_b.push_back(exp);
                else q_a.push_back(exp);
            end
            prev = cur;
            if (n == spam_n) begin
                a_start = 1'b1;
                @(negedge clk);
                a_start = 1'b0;
                @(negedge clk);
            end else begin
                repeat (2) @(negedge clk);
            end
            sd_dclk = 1'b0;
            repeat (2 + (fast ? 0 : int'($urandom_range(0, 2)))) @(negedge clk);
        end
    endtask

    task automatic serve(input bit to_b, input int t, input int nbytes, input logic [15:0] exp_sec,
                         input bit strays, input bit fast, input bit spam);
        int nstray;
        repeat (2) @(negedge clk);
        chk(to_b ? "b_sector_addr" : "a_sector_addr", {16'h0, to_b ? b_addr : a_addr}, {16'h0, exp_sec});
        if (strays) begin
            nstray = int'($urandom_range(1, 3));
            for (int k = 0; k < nstray; k++) begin
                sd_data = 8'($urandom);
                sd_dclk = 1'b1;
                repeat (2) @(negedge clk);
                sd_dclk = 1'b0;
                repeat (2) @(negedge clk);
            end
            repeat (4) @(negedge clk);
        end
        sd_en = 1'b1;
        repeat (6) @(negedge clk);
        send_bytes(to_b, t, nbytes, fast, spam);
        repeat (4) @(negedge clk);
        sd_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        chk("a_busy_rise", {31'b0, a_busy}, 32'd1);
        chk("a_done_clear", {31'b0, a_done}, 32'd0);
        chk("a_err_clear", {31'b0, a_err}, 32'd0);
        @(negedge clk);
        a_start = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        a_wr_cnt = 0; b_wr_cnt = 0; a_last_wr = 0; a_done_cyc = 0;
        a_done_d = 1'b0; a_px300 = 16'hDEAD;
        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
        sd_data = 8'h00; sd_dclk = 1'b0; sd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_addr", {16'h0, a_addr}, 32'h0002);
        chk("rst_b_addr", {16'h0, b_addr}, 32'hFFFF);
        chk("rst_a_outs", {a_wr_en, a_busy, a_done, a_err}, 32'd0);
        chk("rst_a_wr", {3'b0, a_wr_addr, a_wr_data}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of sector 0, with an odd byte still in the synchronizer.
        pulse_start_a();
        repeat (2) @(negedge clk);
        chk("a_first_sector", {16'h0, a_addr}, 32'h0002);
        sd_en = 1'b1;
        repeat (6) @(negedge clk);
        send_bytes(1'b0, 0, 100, 1'b0, 1'b0);
        sd_data = 8'd100; sd_dclk = 1'b1;
        repeat (2) @(negedge clk);
        sd_dclk = 1'b0;
        repeat (2) @(negedge clk);
        sd_data = 8'd101; sd_dclk = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {a_wr_en, a_busy, a_done, a_err}, 32'd0);
        chk("midrst_wr", {3'b0, a_wr_addr, a_wr_data}, 32'd0);
        chk("midrst_addr", {16'h0, a_addr}, 32'h0002);
        repeat (2) @(negedge clk);
        q_a.delete();
        sd_dclk = 1'b0; sd_en = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_wr_cnt", 32'(a_wr_cnt), 32'd50);

        // Full load with stray edges in REQ and Start pulses during reception.
        a_wr_cnt = 0;
        pulse_start_a();
        for (int t = 0; t < 32; t++) serve(1'b0, t, 512, 16'(2 + t), 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 50 && !a_done; k++) @(negedge clk);
        chk("full_done", {31'b0, a_done}, 32'd1);
        chk("full_err", {31'b0, a_err}, 32'd0);
        chk("full_busy", {31'b0, a_busy}, 32'd0);
        chk("full_wr_cnt", 32'(a_wr_cnt), 32'd8192);
        chk("full_queue_empty", 32'(q_a.size()), 32'd0);
        chk("done_after_last_wr", 32'(a_done_cyc - a_last_wr), 32'd2);
`ifdef SD_TILE_LOADER_LITTLE_ENDIAN_EN
        chk("tile3_px0", {16'h0, a_px300}, 32'h0403);
`else
        chk("tile3_px0", {16'h0, a_px300}, 32'h0304);
`endif

        // Abort: enable dropped after 301 bytes of sector 5.
        a_wr_cnt = 0;
        pulse_start_a();
        for (int t = 0; t < 3; t++) serve(1'b0, t, 512, 16'(2 + t), 1'b0, 1'b0, 1'b0);
        serve(1'b0, 3, 301, 16'h0005, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_err", {31'b0, a_err}, 32'd1);
        chk("abort_busy", {31'b0, a_busy}, 32'd0);
        chk("abort_done", {31'b0, a_done}, 32'd0);
        chk("abort_addr", {16'h0, a_addr}, 32'h0005);
        chk("abort_wr_cnt", 32'(a_wr_cnt), 32'd918);
        q_a.delete();

        // Two-tile instance starting at 0xFFFF: address wraps to 0x0000.
        b_wr_cnt = 0;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_busy", {31'b0, b_busy}, 32'd1);
        serve(1'b1, 0, 512, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        serve(1'b1, 1, 512, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 50 && !b_done; k++) @(negedge clk);
        chk("b_done", {31'b0, b_done}, 32'd1);
        chk("b_err", {31'b0, b_err}, 32'd0);
        chk("b_wr_cnt", 32'(b_wr_cnt), 32'd512);
        chk("b_queue_empty", 32'(q_b.size()), 32'd0);
        chk("a_idle_no_writes", 32'(a_wr_cnt), 32'd918);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
